// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver with a "<bank payload>" frame decoder.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote
// over three consecutive synchronised samples centred on mid-bit.
module uart_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 54,
    parameter int unsigned MAX_BYTES    = 32,
    parameter logic [7:0]  SOF_CHAR     = 8'h3C,
    parameter logic [7:0]  EOF_CHAR     = 8'h3E
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rxd,
    output logic [8*MAX_BYTES-1:0]             data_out,
    output logic [7:0]                         bank,
    output logic [$clog2(MAX_BYTES+1)-1:0]     data_len,
    output logic                               frame_valid,
    output logic                               frame_err,
    output logic [7:0]                         byte_out,
    output logic                               byte_valid
);

    localparam int unsigned DW   = 8 * MAX_BYTES;
    localparam int unsigned LW   = $clog2(MAX_BYTES + 1);
    localparam int unsigned CNTW = $clog2(CLKS_PER_BIT + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned START_PT = CLKS_PER_BIT / 2 + 1;
`else
    localparam int unsigned START_PT = CLKS_PER_BIT / 2;
`endif

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [1:0] {F_IDLE, F_BANK, F_DATA} fstate_t;

    // ---------------- synchroniser and bit sample ----------------
    logic r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic w_sample;

`ifdef UART_RX_MAJORITY_EN
    logic r_rxd_prev2;

    // Third history flop feeding the majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rxd_prev2 <= 1'b1;
        else        r_rxd_prev2 <= r_rxd_prev;
    end

    assign w_sample = (r_rxd_sync & r_rxd_prev) | (r_rxd_sync & r_rxd_prev2) |
                      (r_rxd_prev & r_rxd_prev2);
`else
    assign w_sample = r_rxd_sync;
`endif

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // ---------------- bit FSM ----------------
    bstate_t          r_bstate, w_bstate_n;
    logic [CNTW-1:0]  r_bcnt, w_bcnt_n;
    logic [2:0]       r_bit_idx, w_bit_idx_n;
    logic [7:0]       r_shift, w_shift_n;
    logic [7:0]       r_byte_out, w_byte_out_n;
    logic             r_byte_valid, w_byte_valid_n;
    logic             w_rx_ferr;

    // Bit FSM state and byte output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate     <= B_IDLE;
            r_bcnt       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_bstate     <= w_bstate_n;
            r_bcnt       <= w_bcnt_n;
            r_bit_idx    <= w_bit_idx_n;
            r_shift      <= w_shift_n;
            r_byte_out   <= w_byte_out_n;
            r_byte_valid <= w_byte_valid_n;
        end
    end

    // Bit FSM next state: cycle counter restarts at 1 after every decision
    always_comb begin
        w_bstate_n     = r_bstate;
        w_bcnt_n       = r_bcnt + CNTW'(1);
        w_bit_idx_n    = r_bit_idx;
        w_shift_n      = r_shift;
        w_byte_out_n   = r_byte_out;
        w_byte_valid_n = 1'b0;
        w_rx_ferr      = 1'b0;
        case (r_bstate)
            B_IDLE: begin
                w_bcnt_n = CNTW'(1);
                if (r_rxd_prev && !r_rxd_sync) w_bstate_n = B_START;
            end
            B_START: begin
                if (r_bcnt == CNTW'(START_PT)) begin
                    w_bcnt_n = CNTW'(1);
                    if (w_sample) begin
                        w_bstate_n = B_IDLE;
                    end else begin
                        w_bstate_n  = B_DATA;
                        w_bit_idx_n = 3'd0;
                    end
                end
            end
            B_DATA: begin
                if (r_bcnt == CNTW'(CLKS_PER_BIT)) begin
                    w_bcnt_n    = CNTW'(1);
                    w_shift_n   = {w_sample, r_shift[7:1]};
                    w_bit_idx_n = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_bstate_n = B_STOP;
                end
            end
            B_STOP: begin
                if (r_bcnt == CNTW'(CLKS_PER_BIT)) begin
                    w_bcnt_n   = CNTW'(1);
                    w_bstate_n = B_IDLE;
                    if (w_sample) begin
                        w_byte_valid_n = 1'b1;
                        w_byte_out_n   = r_shift;
                    end else begin
                        w_rx_ferr = 1'b1;
                    end
                end
            end
            default: w_bstate_n = B_IDLE;
        endcase
    end

    // ---------------- frame FSM ----------------
    fstate_t          r_fstate, w_fstate_n;
    logic [LW-1:0]    r_fcount, w_fcount_n;
    logic [DW-1:0]    r_buf, w_buf_n;
    logic [7:0]       r_bank_tmp, w_bank_tmp_n;
    logic [DW-1:0]    r_data_out, w_data_out_n;
    logic [7:0]       r_bank, w_bank_n;
    logic [LW-1:0]    r_data_len, w_data_len_n;
    logic             r_frame_valid, w_frame_valid_n;
    logic             r_frame_err, w_frame_err_n;

    // Frame FSM state, assembly buffer and committed outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate      <= F_IDLE;
            r_fcount      <= '0;
            r_buf         <= '0;
            r_bank_tmp    <= '0;
            r_data_out    <= '0;
            r_bank        <= '0;
            r_data_len    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_fstate      <= w_fstate_n;
            r_fcount      <= w_fcount_n;
            r_buf         <= w_buf_n;
            r_bank_tmp    <= w_bank_tmp_n;
            r_data_out    <= w_data_out_n;
            r_bank        <= w_bank_n;
            r_data_len    <= w_data_len_n;
            r_frame_valid <= w_frame_valid_n;
            r_frame_err   <= w_frame_err_n;
        end
    end

    // Frame FSM next state: consumes the registered byte strobe, or a stop-bit error
    always_comb begin
        w_fstate_n      = r_fstate;
        w_fcount_n      = r_fcount;
        w_buf_n         = r_buf;
        w_bank_tmp_n    = r_bank_tmp;
        w_data_out_n    = r_data_out;
        w_bank_n        = r_bank;
        w_data_len_n    = r_data_len;
        w_frame_valid_n = 1'b0;
        w_frame_err_n   = 1'b0;
        if (w_rx_ferr) begin
            if (r_fstate != F_IDLE) begin
                w_frame_err_n = 1'b1;
                w_fstate_n    = F_IDLE;
            end
        end else if (r_byte_valid) begin
            case (r_fstate)
                F_IDLE: begin
                    if (r_byte_out == SOF_CHAR) w_fstate_n = F_BANK;
                end
                F_BANK: begin
                    w_bank_tmp_n = r_byte_out;
                    w_fcount_n   = '0;
                    w_buf_n      = '0;
                    w_fstate_n   = F_DATA;
                end
                F_DATA: begin
                    if (r_byte_out == EOF_CHAR) begin
                        w_data_out_n    = r_buf;
                        w_bank_n        = r_bank_tmp;
                        w_data_len_n    = r_fcount;
                        w_frame_valid_n = 1'b1;
                        w_fstate_n      = F_IDLE;
                    end else if (r_byte_out == SOF_CHAR) begin
                        w_buf_n    = '0;
                        w_fcount_n = '0;
                        w_fstate_n = F_BANK;
                    end else if (r_fcount == LW'(MAX_BYTES)) begin
                        w_frame_err_n = 1'b1;
                        w_fstate_n    = F_IDLE;
                    end else begin
                        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                            if (r_fcount == LW'(i)) w_buf_n[8*i +: 8] = r_byte_out;
                        end
                        w_fcount_n = r_fcount + LW'(1);
                    end
                end
                default: w_fstate_n = F_IDLE;
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign bank        = r_bank;
    assign data_len    = r_data_len;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus a queue-based frame model.
module tb_uart_frame_rx;

    localparam int CPB  = 54;
    localparam int MAXB = 32;
    localparam logic [7:0] SOF = 8'h3C;
    localparam logic [7:0] EOF = 8'h3E;

    logic         clk, rst_n, rxd;
    logic [255:0] data_out;
    logic [7:0]   bank, byte_out;
    logic [5:0]   data_len;
    logic         frame_valid, frame_err, byte_valid;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .data_out(data_out), .bank(bank), .data_len(data_len),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .byte_out(byte_out), .byte_valid(byte_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int vectors, miscompares;
    int fv_seen, fe_seen, bv_seen;

    // bytes the sender expects to be received, in order
    logic [7:0] exp_byte [0:511];
    int exp_wr, exp_rd;
    int ferr_req, ferr_done, ferr_allow;

    // frame model
    int           mst;              // 0 waiting for SOF, 1 expecting bank, 2 payload
    logic [7:0]   payload [$];
    logic [7:0]   m_btmp, m_bank, pend_bank;
    logic [255:0] m_data, pend_data;
    logic [5:0]   m_len, pend_len;
    bit           pend_commit, pend_ovf;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mst = 0; payload.delete(); m_btmp = '0;
        m_data = '0; m_bank = '0; m_len = '0;
        pend_commit = 0; pend_ovf = 0; ferr_allow = 0;
    endtask

    task automatic m_step(input logic [7:0] b);
        case (mst)
            0: if (b == SOF) mst = 1;
            1: begin m_btmp = b; payload.delete(); mst = 2; end
            default: begin
                if (b == EOF) begin
                    pend_commit = 1; pend_bank = m_btmp;
                    pend_len = 6'(payload.size()); pend_data = '0;
                    foreach (payload[i]) pend_data[8*i +: 8] = payload[i];
                    mst = 0;
                end else if (b == SOF) begin
                    payload.delete(); mst = 1;
                end else if (payload.size() == MAXB) begin
                    pend_ovf = 1; mst = 0;
                end else begin
                    payload.push_back(b);
                end
            end
        endcase
    endtask

    // Single compare process: checks every cycle against the model
    task automatic monitor();
        bit exp_fv, exp_fe;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_reset(); exp_rd = exp_wr; ferr_done = ferr_req;
            end
            exp_fv = pend_commit; exp_fe = pend_ovf;
            if (pend_commit) begin m_data = pend_data; m_bank = pend_bank; m_len = pend_len; end
            pend_commit = 0; pend_ovf = 0;
            chk("frame_valid", 256'(frame_valid), 256'(exp_fv));
            chk("data_out", data_out, m_data);
            chk("bank", 256'(bank), 256'(m_bank));
            chk("data_len", 256'(data_len), 256'(m_len));
            if (exp_fe) chk("frame_err_overflow", 256'(frame_err), 256'(1));
            else if (frame_err) begin
                if (ferr_allow > 0) ferr_allow--;
                else chk("frame_err_spurious", 256'(frame_err), 256'(0));
            end
            if (frame_valid) fv_seen++;
            if (frame_err)   fe_seen++;
            if (byte_valid)  bv_seen++;
            if (ferr_req != ferr_done) begin
                ferr_done++;
                if (mst != 0) ferr_allow++;
                mst = 0; payload.delete();
            end
            if (byte_valid && rst_n) begin
                if (exp_rd == exp_wr) chk("byte_unexpected", 256'(byte_valid), 256'(0));
                else begin
                    b = exp_byte[exp_rd]; exp_rd++;
                    chk("byte_out", 256'(byte_out), 256'(b));
                    m_step(b);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit spike);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        if (stop_ok) begin exp_byte[exp_wr] = b; exp_wr++; end
        for (int i = 0; i < 10; i++) begin
            if (i == 9 && !stop_ok) ferr_req++;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                rxd = (spike && c == CPB / 2) ? ~fr[i] : fr[i];
            end
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit spike);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, spike);
    endtask

    initial begin
        int f0, e0, b0;
        vectors = 0; miscompares = 0; fv_seen = 0; fe_seen = 0; bv_seen = 0;
        exp_wr = 0; exp_rd = 0; ferr_req = 0; ferr_done = 0;
        m_reset(); pend_bank = '0; pend_data = '0; pend_len = '0;
        rst_n = 1'b0; rxd = 1'b1;
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        chk("reset_data_out", data_out, 256'(0));
        chk("reset_bank", 256'(bank), 256'(0));
        chk("reset_len", 256'(data_len), 256'(0));
        chk("reset_pulses", 256'({frame_valid, frame_err, byte_valid}), 256'(0));
        chk("reset_byte_out", 256'(byte_out), 256'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: basic frame
        f0 = fv_seen; b0 = bv_seen;
        send_str("<0120>", 1'b0);
        chk("t1_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t1_bv_count", 256'(bv_seen - b0), 256'(6));
        chk("t1_bank", 256'(bank), 256'(8'h30));
        chk("t1_len", 256'(data_len), 256'(3));
        chk("t1_data", data_out, 256'h303231);

        // 2: empty frame, then an unterminated one
        f0 = fv_seen;
        send_str("<0>", 1'b0);
        chk("t2_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t2_len", 256'(data_len), 256'(0));
        chk("t2_data", data_out, 256'(0));
        f0 = fv_seen;
        send_str("<5AB", 1'b0);
        chk("t2_no_fv", 256'(fv_seen - f0), 256'(0));
        chk("t2_bank_hold", 256'(bank), 256'(8'h30));
        chk("t2_len_hold", 256'(data_len), 256'(0));

        // 3: overflow
        e0 = fe_seen; f0 = fv_seen;
        send_str("<1", 1'b0);
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(8'h41 + i), 1'b1, 1'b0);
            if (i == 31) chk("t3_no_early_err", 256'(fe_seen - e0), 256'(0));
        end
        chk("t3_fe_count", 256'(fe_seen - e0), 256'(1));
        send_str(">", 1'b0);
        chk("t3_no_fv", 256'(fv_seen - f0), 256'(0));
        send_str("<1Z>", 1'b0);
        chk("t3_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t3_len", 256'(data_len), 256'(1));
        chk("t3_data", data_out, 256'h5A);
        chk("t3_bank", 256'(bank), 256'(8'h31));

        // 4: stop-bit error inside a frame, then a short glitch on idle line
        e0 = fe_seen; b0 = bv_seen;
        send_str("<0", 1'b0);
        send_byte(8'h41, 1'b0, 1'b0);
        chk("t4_fe_count", 256'(fe_seen - e0), 256'(1));
        chk("t4_bv_count", 256'(bv_seen - b0), 256'(2));
        chk("t4_ferr_pending", 256'(ferr_allow), 256'(0));
        b0 = bv_seen;
        @(negedge clk); rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("t4_glitch_bv", 256'(bv_seen - b0), 256'(0));

        // 5: restart on SOF inside payload
        f0 = fv_seen; e0 = fe_seen;
        send_str("<0AB<3C>", 1'b0);
        chk("t5_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t5_fe_count", 256'(fe_seen - e0), 256'(0));
        chk("t5_bank", 256'(bank), 256'(8'h33));
        chk("t5_len", 256'(data_len), 256'(1));
        chk("t5_data", data_out, 256'h43);

        // 6: reset mid-byte of a payload
        send_str("<0A", 1'b0);
        @(negedge clk); rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0; rxd = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_rst_data", data_out, 256'(0));
        chk("t6_rst_bank", 256'(bank), 256'(0));
        chk("t6_rst_len", 256'(data_len), 256'(0));
        chk("t6_rst_byte_out", 256'(byte_out), 256'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        f0 = fv_seen; e0 = fe_seen;
        send_str("<0AB>", 1'b0);
        chk("t6_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t6_fe_count", 256'(fe_seen - e0), 256'(0));
        chk("t6_len", 256'(data_len), 256'(2));
        chk("t6_data", data_out, 256'h4241);

`ifdef UART_RX_MAJORITY_EN
        // 7: single-cycle spikes at mid-bit are voted out
        f0 = fv_seen;
        send_str("<0A>", 1'b1);
        chk("t7_fv_count", 256'(fv_seen - f0), 256'(1));
        chk("t7_len", 256'(data_len), 256'(1));
        chk("t7_data", data_out, 256'h41);
        chk("t7_bank", 256'(bank), 256'(8'h30));
`endif

        repeat (20) @(negedge clk);
        chk("all_bytes_seen", 256'(exp_wr - exp_rd), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
